// File: rtl/aes_inv_key_sched_pkg.sv
// AES-128 shared definitions: key/word types, SBOX, RCON, round count.
// Used by the reverse key scheduler and the SubWord helper.
package aes_inv_key_sched_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int IDX_W      = 4;

  typedef logic [0:127] aes_key_t;
  typedef logic [31:0]  aes_word_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Indexed by round number; entries outside 1..10 are never used.
  localparam logic [7:0] RCON [0:15] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

endpackage

// File: rtl/aes_inv_key_sched_if.sv
// Round-key stream: key, round index, valid/ready handshake.
// master = key producer, slave = key consumer.
interface aes_inv_key_sched_if;
  import aes_inv_key_sched_pkg::*;

  aes_key_t         round_key_o;
  logic [IDX_W-1:0] round_idx_o;
  logic             key_valid_o;
  logic             key_ready_i;

  modport master (
    output round_key_o,
    output round_idx_o,
    output key_valid_o,
    input  key_ready_i
  );

  modport slave (
    input  round_key_o,
    input  round_idx_o,
    input  key_valid_o,
    output key_ready_i
  );

endinterface

// File: rtl/aes_inv_key_sched_sub_word.sv
// AES SubWord: four parallel SBOX lookups, purely combinational.
// Ports: word (32-bit in), sub (32-bit substituted out).
module aes_sub_word
  import aes_inv_key_sched_pkg::*;
(
  input  aes_word_t word,
  output aes_word_t sub
);

  assign sub[31:24] = SBOX[word[31:24]];
  assign sub[23:16] = SBOX[word[23:16]];
  assign sub[15:8]  = SBOX[word[15:8]];
  assign sub[7:0]   = SBOX[word[7:0]];

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 reverse key scheduler: round 10 key in, rounds 10..0 out.
// Ports: clk, rst, start_i, last_key_i, busy_o, done_o, cipher_key_o, kif.
module aes_inv_key_sched
  import aes_inv_key_sched_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  aes_key_t                    last_key_i,
  output logic                        busy_o,
  output logic                        done_o,
  output aes_key_t                    cipher_key_o,
  aes_inv_key_sched_if.master         kif
);

  state_t           state, state_n;
  aes_key_t         key_q, key_n;
  aes_key_t         ck_q, ck_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic             valid_q, valid_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;

  aes_word_t w0, w1, w2, w3;
  aes_word_t p0, p1, p2, p3;
  aes_word_t sw;
  logic      hs;

  assign w0 = key_q[0:31];
  assign w1 = key_q[32:63];
  assign w2 = key_q[64:95];
  assign w3 = key_q[96:127];

  // Undo the forward XOR chain; p3 is the previous key's last word.
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;

  aes_sub_word u_sub (
    .word ({p3[23:0], p3[31:24]}),
    .sub  (sw)
  );

  assign p0 = w0 ^ sw ^ {RCON[idx_q], 24'h0};
  assign hs = valid_q && kif.key_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      key_q   <= '0;
      ck_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      key_q   <= key_n;
      ck_q    <= ck_n;
      idx_q   <= idx_n;
      valid_q <= valid_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    key_n   = key_q;
    ck_n    = ck_q;
    idx_n   = idx_q;
    valid_n = valid_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          key_n   = last_key_i;
          idx_n   = IDX_W'(NUM_ROUNDS);
          valid_n = 1'b1;
          busy_n  = 1'b1;
          state_n = EMIT;
        end
      end
      EMIT: begin
        if (hs) begin
          if (idx_q != '0) begin
            key_n = {p0, p1, p2, p3};
            idx_n = idx_q - 1'b1;
          end else begin
            ck_n    = key_q;
            valid_n = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
      end
    endcase
  end

  assign kif.round_key_o = key_q;
  assign kif.round_idx_o = idx_q;
  assign kif.key_valid_o = valid_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign cipher_key_o    = ck_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for aes_inv_key_sched: FIPS-197 vectors, backpressure, aborts.
// Reference: forward key expansion with a GF(2^8)-derived SBOX.
module tb_aes_inv_key_sched;
  import aes_inv_key_sched_pkg::*;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  logic     start_i = 1'b0;
  aes_key_t last_key_i = '0;
  logic     busy_o;
  logic     done_o;
  aes_key_t cipher_key_o;

  aes_inv_key_sched_if kif ();

  aes_inv_key_sched dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .last_key_i   (last_key_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .cipher_key_o (cipher_key_o),
    .kif          (kif)
  );

  always #5 clk = ~clk;

  localparam aes_key_t FIPS_CK = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam aes_key_t FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam aes_key_t FIPS_RK9 = 128'hac7766f319fadc2128d12941575c006e;
  localparam aes_key_t FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam aes_key_t ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] sb [256];
  aes_key_t   exp_key [11];
  aes_key_t   cap_key [11];
  int         cap_idx [11];
  int         nhs, done_cnt, busy_bad, ncyc;
  bit         stable, timeout, rst_hit;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // SBOX = affine transform of the multiplicative inverse in GF(2^8).
  function automatic void build_sbox();
    logic [7:0] inv, s, r;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
      s = inv ^ 8'h63;
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sb[b] = s;
    end
  endfunction

  // Standard forward AES-128 key expansion into exp_key[0..10].
  function automatic void expand(input aes_key_t ck);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = ck[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      exp_key[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Drives one sequence and records what the consumer accepted.
  // Called and returns at a falling edge (except after a reset hit).
  task automatic run_seq(input aes_key_t k, input bit do_start,
                         input int rdy_pct, input int inj_idx,
                         input aes_key_t inj_key, input int rst_idx);
    aes_key_t pk;
    int       pi;
    bit       stall, injected;
    pk = '0; pi = 0; stall = 0; injected = 0;
    nhs = 0; done_cnt = 0; busy_bad = 0; ncyc = -1;
    stable = 1; timeout = 1; rst_hit = 0;
    if (do_start) begin
      start_i = 1'b1;
      last_key_i = k;
      kif.key_ready_i = 1'b0;
      @(negedge clk);
      start_i = 1'b0;
    end
    for (int c = 0; c < 500; c++) begin
      if (stall && (kif.round_key_o !== pk ||
                    int'(kif.round_idx_o) != pi ||
                    kif.key_valid_o !== 1'b1)) stable = 0;
      if (kif.key_valid_o && !busy_o) busy_bad++;
      if (done_o) begin
        done_cnt++;
        if (nhs >= 11) begin
          timeout = 0;
          ncyc = c;
          break;
        end
      end
      if (rst_idx >= 0 && kif.key_valid_o &&
          int'(kif.round_idx_o) == rst_idx) begin
        rst = 1'b1;
        #1;
        rst_hit = 1;
        timeout = 0;
        break;
      end
      start_i = 1'b0;
      if (inj_idx >= 0 && !injected && kif.key_valid_o &&
          int'(kif.round_idx_o) == inj_idx) begin
        start_i = 1'b1;
        last_key_i = inj_key;
        injected = 1;
      end
      kif.key_ready_i = ($urandom_range(0, 99) < rdy_pct);
      if (kif.key_valid_o && kif.key_ready_i) begin
        if (nhs < 11) begin
          cap_key[nhs] = kif.round_key_o;
          cap_idx[nhs] = int'(kif.round_idx_o);
        end
        nhs++;
      end
      stall = kif.key_valid_o && !kif.key_ready_i;
      pk = kif.round_key_o;
      pi = int'(kif.round_idx_o);
      @(negedge clk);
    end
    start_i = 1'b0;
    kif.key_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++; if (kif.round_key_o !== '0) begin n_err++;
      $display("FAIL rst_key got %h want 0", kif.round_key_o); end
    n_vec++; if (kif.round_idx_o !== '0) begin n_err++;
      $display("FAIL rst_idx got %0d want 0", kif.round_idx_o); end
    n_vec++; if (kif.key_valid_o !== 1'b0) begin n_err++;
      $display("FAIL rst_valid got %b want 0", kif.key_valid_o); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++;
      $display("FAIL rst_busy got %b want 0", busy_o); end
    n_vec++; if (done_o !== 1'b0) begin n_err++;
      $display("FAIL rst_done got %b want 0", done_o); end
    n_vec++; if (cipher_key_o !== '0) begin n_err++;
      $display("FAIL rst_ck got %h want 0", cipher_key_o); end
    rst = 1'b0;
    kif.key_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (kif.key_valid_o !== 1'b0) begin n_err++;
      $display("FAIL idle_valid got %b want 0", kif.key_valid_o); end
    kif.key_ready_i = 1'b0;
  endtask

  task automatic test_fips();
    expand(FIPS_CK);
    run_seq(FIPS_RK10, 1, 100, -1, '0, -1);
    n_vec++; if (timeout || nhs != 11) begin n_err++;
      $display("FAIL fips_hs got %0d to=%0d want 11", nhs, timeout); end
    for (int n = 0; n < 11; n++) begin
      n_vec++; if (cap_idx[n] != 10 - n || cap_key[n] !== exp_key[10-n]) begin
        n_err++;
        $display("FAIL fips_beat%0d got %0d/%h want %0d/%h",
                 n, cap_idx[n], cap_key[n], 10 - n, exp_key[10-n]);
      end
    end
    n_vec++; if (cap_key[0] !== FIPS_RK10) begin n_err++;
      $display("FAIL fips_rk10 got %h want %h", cap_key[0], FIPS_RK10); end
    n_vec++; if (cap_key[1] !== FIPS_RK9) begin n_err++;
      $display("FAIL fips_rk9 got %h want %h", cap_key[1], FIPS_RK9); end
    n_vec++; if (cap_key[9] !== FIPS_RK1) begin n_err++;
      $display("FAIL fips_rk1 got %h want %h", cap_key[9], FIPS_RK1); end
    n_vec++; if (cap_key[10] !== FIPS_CK) begin n_err++;
      $display("FAIL fips_rk0 got %h want %h", cap_key[10], FIPS_CK); end
    n_vec++; if (cipher_key_o !== FIPS_CK) begin n_err++;
      $display("FAIL fips_ck got %h want %h", cipher_key_o, FIPS_CK); end
    n_vec++; if (ncyc != 11) begin n_err++;
      $display("FAIL fips_latency got %0d want 11", ncyc); end
    n_vec++; if (busy_o !== 1'b0 || kif.key_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL fips_end got busy=%b valid=%b want 0/0",
               busy_o, kif.key_valid_o);
    end
    n_vec++; if (busy_bad != 0) begin n_err++;
      $display("FAIL fips_busy got %0d want 0", busy_bad); end
    @(negedge clk);
    n_vec++; if (done_o !== 1'b0) begin n_err++;
      $display("FAIL fips_done_pulse got %b want 0", done_o); end
    n_vec++; if (cipher_key_o !== FIPS_CK) begin n_err++;
      $display("FAIL fips_ck_hold got %h want %h", cipher_key_o, FIPS_CK); end
  endtask

  task automatic test_zero();
    expand('0);
    run_seq(ZERO_RK10, 1, 100, -1, '0, -1);
    n_vec++; if (timeout || nhs != 11) begin n_err++;
      $display("FAIL zero_hs got %0d want 11", nhs); end
    for (int n = 0; n < 11; n++) begin
      n_vec++; if (cap_key[n] !== exp_key[10-n]) begin n_err++;
        $display("FAIL zero_beat%0d got %h want %h", n, cap_key[n], exp_key[10-n]);
      end
    end
    n_vec++; if (cap_key[10] !== '0 || cipher_key_o !== '0) begin
      n_err++;
      $display("FAIL zero_ck got %h/%h want 0", cap_key[10], cipher_key_o);
    end
  endtask

  task automatic test_backpressure();
    expand(FIPS_CK);
    run_seq(FIPS_RK10, 1, 30, -1, '0, -1);
    n_vec++; if (timeout || nhs != 11) begin n_err++;
      $display("FAIL bp_hs got %0d to=%0d want 11", nhs, timeout); end
    n_vec++; if (!stable) begin n_err++;
      $display("FAIL bp_stable got 0 want 1"); end
    n_vec++; if (done_cnt != 1) begin n_err++;
      $display("FAIL bp_done got %0d want 1", done_cnt); end
    for (int n = 0; n < 11; n++) begin
      n_vec++; if (cap_idx[n] != 10 - n || cap_key[n] !== exp_key[10-n]) begin
        n_err++;
        $display("FAIL bp_beat%0d got %0d/%h want %0d/%h",
                 n, cap_idx[n], cap_key[n], 10 - n, exp_key[10-n]);
      end
    end
    n_vec++; if (cipher_key_o !== FIPS_CK) begin n_err++;
      $display("FAIL bp_ck got %h want %h", cipher_key_o, FIPS_CK); end
  endtask

  task automatic test_start_ignored();
    aes_key_t other;
    other = {$urandom, $urandom, $urandom, $urandom};
    expand(FIPS_CK);
    run_seq(FIPS_RK10, 1, 100, 6, other, -1);
    n_vec++; if (timeout || nhs != 11) begin n_err++;
      $display("FAIL inj_hs got %0d want 11", nhs); end
    for (int n = 0; n < 11; n++) begin
      n_vec++; if (cap_key[n] !== exp_key[10-n]) begin n_err++;
        $display("FAIL inj_beat%0d got %h want %h", n, cap_key[n], exp_key[10-n]);
      end
    end
    n_vec++; if (cipher_key_o !== FIPS_CK) begin n_err++;
      $display("FAIL inj_ck got %h want %h", cipher_key_o, FIPS_CK); end
  endtask

  task automatic test_reset_mid();
    expand(FIPS_CK);
    run_seq(FIPS_RK10, 1, 100, -1, '0, 4);
    n_vec++; if (!rst_hit) begin n_err++;
      $display("FAIL rmid_hit got 0 want 1"); end
    n_vec++; if (kif.round_key_o !== '0 || kif.round_idx_o !== '0 ||
                 kif.key_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_stream got %h/%0d/%b want 0/0/0",
               kif.round_key_o, kif.round_idx_o, kif.key_valid_o);
    end
    n_vec++; if (busy_o !== 1'b0 || done_o !== 1'b0 || cipher_key_o !== '0) begin
      n_err++;
      $display("FAIL rmid_ctl got %b/%b/%h want 0/0/0",
               busy_o, done_o, cipher_key_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_seq(FIPS_RK10, 1, 100, -1, '0, -1);
    n_vec++; if (timeout || nhs != 11) begin n_err++;
      $display("FAIL rmid_hs got %0d want 11", nhs); end
    for (int n = 0; n < 11; n++) begin
      n_vec++; if (cap_key[n] !== exp_key[10-n]) begin n_err++;
        $display("FAIL rmid_beat%0d got %h want %h", n, cap_key[n], exp_key[10-n]);
      end
    end
    n_vec++; if (cipher_key_o !== FIPS_CK) begin n_err++;
      $display("FAIL rmid_ck got %h want %h", cipher_key_o, FIPS_CK); end
  endtask

  task automatic test_back_to_back();
    expand(FIPS_CK);
    run_seq(FIPS_RK10, 1, 100, -1, '0, -1);
    n_vec++; if (done_o !== 1'b1) begin n_err++;
      $display("FAIL b2b_done got %b want 1", done_o); end
    start_i = 1'b1;
    last_key_i = ZERO_RK10;
    @(negedge clk);
    start_i = 1'b0;
    n_vec++; if (kif.key_valid_o !== 1'b1 || int'(kif.round_idx_o) != 10 ||
                 kif.round_key_o !== ZERO_RK10) begin
      n_err++;
      $display("FAIL b2b_first got %b/%0d/%h want 1/10/%h",
               kif.key_valid_o, kif.round_idx_o, kif.round_key_o, ZERO_RK10);
    end
    expand('0);
    run_seq('0, 0, 100, -1, '0, -1);
    n_vec++; if (timeout || nhs != 11) begin n_err++;
      $display("FAIL b2b_hs got %0d want 11", nhs); end
    for (int n = 0; n < 11; n++) begin
      n_vec++; if (cap_key[n] !== exp_key[10-n]) begin n_err++;
        $display("FAIL b2b_beat%0d got %h want %h", n, cap_key[n], exp_key[10-n]);
      end
    end
    n_vec++; if (cipher_key_o !== '0) begin n_err++;
      $display("FAIL b2b_ck got %h want 0", cipher_key_o); end
  endtask

  task automatic test_random();
    aes_key_t ck;
    for (int t = 0; t < 4; t++) begin
      ck = {$urandom, $urandom, $urandom, $urandom};
      expand(ck);
      run_seq(exp_key[10], 1, 60, -1, '0, -1);
      n_vec++; if (timeout || nhs != 11 || !stable) begin n_err++;
        $display("FAIL rnd%0d_hs got %0d st=%0d want 11/1", t, nhs, stable);
      end
      for (int n = 0; n < 11; n++) begin
        n_vec++; if (cap_key[n] !== exp_key[10-n]) begin n_err++;
          $display("FAIL rnd%0d_beat%0d got %h want %h",
                   t, n, cap_key[n], exp_key[10-n]);
        end
      end
      n_vec++; if (cipher_key_o !== ck) begin n_err++;
        $display("FAIL rnd%0d_ck got %h want %h", t, cipher_key_o, ck); end
    end
  endtask

  initial begin
    kif.key_ready_i = 1'b0;
    build_sbox();
    test_reset();
    test_fips();
    test_zero();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
